// File: rtl/axi_stream_protocol_checker.sv
// Passive AXI-Stream protocol checker: sticky violation flags with first-error
// capture, plus saturating beat/byte/packet/stall statistics for bring-up.
module axi_stream_protocol_checker #(
   parameter int byte_width       = 4,
   parameter int id_width         = 1,
   parameter int dest_width       = 1,
   parameter int user_width       = 1,
   parameter int max_packet_beats = 256,
   parameter int stall_timeout    = 16,
   parameter int count_width      = 32
) (
   input  logic                    clk,
   input  logic                    resetn,
   input  logic                    tvalid,
   input  logic                    tready,
   input  logic [8*byte_width-1:0] tdata,
   input  logic [byte_width-1:0]   tstrb,
   input  logic [byte_width-1:0]   tkeep,
   input  logic                    tlast,
   input  logic [id_width-1:0]     tid,
   input  logic [dest_width-1:0]   tdest,
   input  logic [user_width-1:0]   tuser,
   input  logic                    clear_errors,
   input  logic                    clear_counters,
   output logic [5:0]              err_flags,
   output logic                    err_any,
   output logic [2:0]              err_first,
   output logic [count_width-1:0]  beat_count,
   output logic [count_width-1:0]  byte_count,
   output logic [count_width-1:0]  packet_count,
   output logic [count_width-1:0]  stall_count,
   output logic                    in_packet,
   output logic [15:0]             pkt_beats
);

   localparam int payload_width = 8*byte_width + 2*byte_width + 1 + id_width + dest_width + user_width;
   localparam int timer_width   = $clog2(stall_timeout + 1);
   localparam int pop_width     = $clog2(byte_width + 1);
   localparam logic [timer_width-1:0] timer_max  = timer_width'(stall_timeout);
   localparam logic [timer_width-1:0] timer_fire = timer_width'(stall_timeout - 1);
   localparam logic [count_width-1:0] count_one  = count_width'(1);

   logic                     handshake;
   logic                     stalled;
   logic [payload_width-1:0] payload;
   logic [payload_width-1:0] snapshot;
   logic                     stalled_q;
   logic [timer_width-1:0]   stall_timer;
   logic [id_width-1:0]      pkt_tid;
   logic [dest_width-1:0]    pkt_tdest;
   logic                     too_long_q;
   logic [16:0]              beats_plus_one;
   logic [pop_width-1:0]     keep_ones;
   logic [count_width:0]     byte_sum;
   logic [5:0]               err_now;
   logic [5:0]               err_next;
   logic [2:0]               first_idx;

   assign handshake      = tvalid && tready;
   assign stalled        = tvalid && !tready;
   assign payload        = {tdata, tstrb, tkeep, tlast, tid, tdest, tuser};
   assign beats_plus_one = {1'b0, pkt_beats} + 17'd1;
   assign byte_sum       = {1'b0, byte_count} + (count_width+1)'(keep_ones);

   always_comb begin
      keep_ones = '0;
      for (int i = 0; i < byte_width; i++) begin
         keep_ones = keep_ones + pop_width'(tkeep[i]);
      end
   end

   // too_long_q suppresses re-firing of PKT_TOO_LONG for the rest of the packet
   always_comb begin
      err_now    = '0;
      err_now[0] = stalled_q && !tvalid;
      err_now[1] = stalled_q && tvalid && (payload != snapshot);
      err_now[2] = tvalid && ((tstrb & ~tkeep) != '0);
      err_now[3] = handshake && !tlast && !too_long_q &&
                   ({15'd0, beats_plus_one} >= 32'(max_packet_beats));
      err_now[4] = stalled && (stall_timer == timer_fire);
      err_now[5] = handshake && in_packet && ((tid != pkt_tid) || (tdest != pkt_tdest));
      err_next   = clear_errors ? err_now : (err_flags | err_now);
      first_idx  = '0;
      for (int i = 5; i >= 0; i--) begin
         if (err_now[i]) first_idx = 3'(i);
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         err_flags <= '0;
         err_any   <= 1'b0;
         err_first <= '0;
      end else begin
         err_flags <= err_next;
         err_any   <= |err_next;
         if ((err_now != '0) && (!err_any || clear_errors)) begin
            err_first <= first_idx;
         end else if (clear_errors) begin
            err_first <= '0;
         end
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         stalled_q   <= 1'b0;
         snapshot    <= '0;
         stall_timer <= '0;
      end else begin
         stalled_q <= stalled;
         if (stalled) begin
            snapshot <= payload;
            if (stall_timer != timer_max) stall_timer <= stall_timer + timer_width'(1);
         end else begin
            stall_timer <= '0;
         end
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         in_packet  <= 1'b0;
         pkt_beats  <= '0;
         pkt_tid    <= '0;
         pkt_tdest  <= '0;
         too_long_q <= 1'b0;
      end else if (handshake) begin
         if (!in_packet) begin
            pkt_tid   <= tid;
            pkt_tdest <= tdest;
         end
         if (tlast) begin
            in_packet  <= 1'b0;
            pkt_beats  <= '0;
            too_long_q <= 1'b0;
         end else begin
            in_packet <= 1'b1;
            if (pkt_beats != 16'hFFFF) pkt_beats <= pkt_beats + 16'd1;
            if (err_now[3]) too_long_q <= 1'b1;
         end
      end
   end

   // Statistics saturate at all-ones; a clear on the same edge beats an increment
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         beat_count   <= '0;
         byte_count   <= '0;
         packet_count <= '0;
         stall_count  <= '0;
      end else if (clear_counters) begin
         beat_count   <= '0;
         byte_count   <= '0;
         packet_count <= '0;
         stall_count  <= '0;
      end else begin
         if (handshake && (beat_count != '1)) beat_count <= beat_count + count_one;
         if (handshake) byte_count <= byte_sum[count_width] ? '1 : byte_sum[count_width-1:0];
         if (handshake && tlast && (packet_count != '1)) packet_count <= packet_count + count_one;
         if (stalled && (stall_count != '1)) stall_count <= stall_count + count_one;
      end
   end

endmodule

// File: tb/tb_axi_stream_protocol_checker.sv
// Directed bench: stimulus pushes expected outputs into a scoreboard queue that
// a negedge monitor pops and compares against the checker outputs.
module tb_axi_stream_protocol_checker;

   logic        clk = 1'b0;
   logic        resetn = 1'b0;
   logic        tvalid = 1'b0;
   logic        tready = 1'b0;
   logic [31:0] tdata = '0;
   logic [3:0]  tstrb = '0;
   logic [3:0]  tkeep = '0;
   logic        tlast = 1'b0;
   logic [0:0]  tid = '0;
   logic [0:0]  tdest = '0;
   logic [0:0]  tuser = '0;
   logic        clear_errors = 1'b0;
   logic        clear_counters = 1'b0;
   logic [5:0]  err_flags;
   logic        err_any;
   logic [2:0]  err_first;
   logic [31:0] beat_count;
   logic [31:0] byte_count;
   logic [31:0] packet_count;
   logic [31:0] stall_count;
   logic        in_packet;
   logic [15:0] pkt_beats;

   typedef enum int {K_FLAGS, K_ANY, K_FIRST, K_BEAT, K_BYTE, K_PKT, K_STALL, K_INPKT, K_PBEATS} kind_t;
   typedef struct {
      string       name;
      kind_t       kind;
      logic [31:0] expected;
   } exp_t;

   exp_t sb[$];
   int   tests_run = 0;
   int   tests_failed = 0;

   axi_stream_protocol_checker #(
      .byte_width(4), .id_width(1), .dest_width(1), .user_width(1),
      .max_packet_beats(8), .stall_timeout(16), .count_width(32)
   ) dut (
      .clk(clk), .resetn(resetn), .tvalid(tvalid), .tready(tready),
      .tdata(tdata), .tstrb(tstrb), .tkeep(tkeep), .tlast(tlast),
      .tid(tid), .tdest(tdest), .tuser(tuser),
      .clear_errors(clear_errors), .clear_counters(clear_counters),
      .err_flags(err_flags), .err_any(err_any), .err_first(err_first),
      .beat_count(beat_count), .byte_count(byte_count),
      .packet_count(packet_count), .stall_count(stall_count),
      .in_packet(in_packet), .pkt_beats(pkt_beats)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] actualOf(kind_t k);
      case (k)
         K_FLAGS:  return {26'd0, err_flags};
         K_ANY:    return {31'd0, err_any};
         K_FIRST:  return {29'd0, err_first};
         K_BEAT:   return beat_count;
         K_BYTE:   return byte_count;
         K_PKT:    return packet_count;
         K_STALL:  return stall_count;
         K_INPKT:  return {31'd0, in_packet};
         default:  return {16'd0, pkt_beats};
      endcase
   endfunction

   // Monitor: drains every pending expectation away from the active edge
   initial begin
      exp_t e;
      logic [31:0] act;
      forever begin
         @(negedge clk);
         while (sb.size() > 0) begin
            e = sb.pop_front();
            act = actualOf(e.kind);
            tests_run++;
            if (act !== e.expected) begin
               tests_failed++;
               $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", e.name, act, e.expected);
            end
         end
      end
   end

   task automatic checkOutput(input string name, input kind_t kind, input logic [31:0] expected);
      exp_t e;
      e.name = name;
      e.kind = kind;
      e.expected = expected;
      sb.push_back(e);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input logic v, input logic r, input logic [31:0] d,
                                input logic [3:0] k, input logic [3:0] s,
                                input logic l, input logic [0:0] id);
      tvalid = v;
      tready = r;
      tdata  = d;
      tkeep  = k;
      tstrb  = s;
      tlast  = l;
      tid    = id;
      tick();
   endtask

   task automatic clearAll();
      clear_errors = 1'b1;
      clear_counters = 1'b1;
      applyStimulus(1'b0, 1'b0, 32'd0, 4'hF, 4'hF, 1'b0, 1'b0);
      clear_errors = 1'b0;
      clear_counters = 1'b0;
   endtask

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      repeat (2) tick();
      checkOutput("reset_flags", K_FLAGS, 32'd0);
      checkOutput("reset_first", K_FIRST, 32'd0);
      checkOutput("reset_beat", K_BEAT, 32'd0);
      checkOutput("reset_inpkt", K_INPKT, 32'd0);
      resetn = 1'b1;

      // Clean traffic: 3 packets x 4 beats
      for (int p = 0; p < 3; p++) begin
         for (int b = 0; b < 4; b++) begin
            applyStimulus(1'b1, 1'b1, 32'(p*16 + b), 4'hF, 4'hF, b == 3, 1'b0);
            if (p == 0 && b == 1) begin
               checkOutput("clean_inpkt_mid", K_INPKT, 32'd1);
               checkOutput("clean_pbeats_mid", K_PBEATS, 32'd2);
            end
         end
      end
      checkOutput("clean_beat", K_BEAT, 32'd12);
      checkOutput("clean_byte", K_BYTE, 32'd48);
      checkOutput("clean_pkt", K_PKT, 32'd3);
      checkOutput("clean_any", K_ANY, 32'd0);
      checkOutput("clean_inpkt_end", K_INPKT, 32'd0);
      checkOutput("clean_stall", K_STALL, 32'd0);
      clear_counters = 1'b1;
      applyStimulus(1'b0, 1'b0, 32'd0, 4'hF, 4'hF, 1'b0, 1'b0);
      clear_counters = 1'b0;
      checkOutput("clrcnt_beat", K_BEAT, 32'd0);
      checkOutput("clrcnt_byte", K_BYTE, 32'd0);

      // Stalled beat whose payload mutates, then tvalid drops
      applyStimulus(1'b1, 1'b0, 32'hA5A5_0001, 4'hF, 4'hF, 1'b0, 1'b0);
      applyStimulus(1'b1, 1'b0, 32'hA5A5_0001, 4'hF, 4'hF, 1'b0, 1'b0);
      checkOutput("stable_flags", K_FLAGS, 32'd0);
      applyStimulus(1'b1, 1'b0, 32'hA5A5_0002, 4'hF, 4'hF, 1'b0, 1'b0);
      checkOutput("mutate_flags", K_FLAGS, 32'h02);
      checkOutput("mutate_first", K_FIRST, 32'd1);
      checkOutput("mutate_any", K_ANY, 32'd1);
      applyStimulus(1'b0, 1'b0, 32'hA5A5_0002, 4'hF, 4'hF, 1'b0, 1'b0);
      checkOutput("drop_flags", K_FLAGS, 32'h03);
      checkOutput("drop_first", K_FIRST, 32'd1);
      checkOutput("drop_stall", K_STALL, 32'd3);
      clear_errors = 1'b1;
      applyStimulus(1'b0, 1'b0, 32'd0, 4'hF, 4'hF, 1'b0, 1'b0);
      clear_errors = 1'b0;
      checkOutput("clrerr_flags", K_FLAGS, 32'd0);
      checkOutput("clrerr_any", K_ANY, 32'd0);

      // Strobe outside keep, then the same violation coinciding with clear_errors
      applyStimulus(1'b1, 1'b1, 32'h1234, 4'b0011, 4'b0100, 1'b1, 1'b0);
      checkOutput("strb_flags", K_FLAGS, 32'h04);
      checkOutput("strb_first", K_FIRST, 32'd2);
      applyStimulus(1'b1, 1'b0, 32'h5678, 4'hF, 4'hF, 1'b0, 1'b0);
      applyStimulus(1'b0, 1'b0, 32'h5678, 4'hF, 4'hF, 1'b0, 1'b0);
      checkOutput("strb_drop_flags", K_FLAGS, 32'h05);
      checkOutput("strb_drop_first", K_FIRST, 32'd2);
      clear_errors = 1'b1;
      applyStimulus(1'b1, 1'b1, 32'h1234, 4'b0011, 4'b0100, 1'b1, 1'b0);
      clear_errors = 1'b0;
      checkOutput("clr_vs_new_flags", K_FLAGS, 32'h04);
      checkOutput("clr_vs_new_first", K_FIRST, 32'd2);
      checkOutput("clr_vs_new_any", K_ANY, 32'd1);
      clearAll();

      // Long packet: max_packet_beats = 8
      for (int i = 1; i <= 8; i++) begin
         applyStimulus(1'b1, 1'b1, 32'(i), 4'hF, 4'hF, 1'b0, 1'b0);
         if (i == 7) checkOutput("long_beat7_flags", K_FLAGS, 32'd0);
      end
      checkOutput("long_flags", K_FLAGS, 32'h08);
      checkOutput("long_first", K_FIRST, 32'd3);
      checkOutput("long_pbeats", K_PBEATS, 32'd8);
      applyStimulus(1'b1, 1'b1, 32'd9, 4'hF, 4'hF, 1'b1, 1'b0);
      checkOutput("long_pkt", K_PKT, 32'd1);
      checkOutput("long_inpkt", K_INPKT, 32'd0);
      checkOutput("long_pbeats_end", K_PBEATS, 32'd0);
      checkOutput("long_beat", K_BEAT, 32'd9);
      checkOutput("long_byte", K_BYTE, 32'd36);
      clearAll();

      // Stall timeout after 16 stalled cycles
      for (int i = 1; i <= 16; i++) begin
         applyStimulus(1'b1, 1'b0, 32'hCAFE, 4'hF, 4'hF, 1'b1, 1'b0);
         if (i == 15) begin
            checkOutput("stall15_flags", K_FLAGS, 32'd0);
            checkOutput("stall15_count", K_STALL, 32'd15);
         end
      end
      checkOutput("stall16_flags", K_FLAGS, 32'h10);
      checkOutput("stall16_first", K_FIRST, 32'd4);
      checkOutput("stall16_count", K_STALL, 32'd16);
      applyStimulus(1'b1, 1'b1, 32'hCAFE, 4'hF, 4'hF, 1'b1, 1'b0);
      checkOutput("stall_release_beat", K_BEAT, 32'd1);
      checkOutput("stall_release_flags", K_FLAGS, 32'h10);
      clearAll();

      // TID switch inside a packet
      applyStimulus(1'b1, 1'b1, 32'h11, 4'hF, 4'hF, 1'b0, 1'b0);
      applyStimulus(1'b1, 1'b1, 32'h12, 4'hF, 4'hF, 1'b1, 1'b1);
      checkOutput("idsw_flags", K_FLAGS, 32'h20);
      checkOutput("idsw_first", K_FIRST, 32'd5);
      clear_errors = 1'b1;
      applyStimulus(1'b0, 1'b0, 32'd0, 4'hF, 4'hF, 1'b0, 1'b0);
      clear_errors = 1'b0;

      // Asynchronous reset in the middle of a packet, with a stall pending
      applyStimulus(1'b1, 1'b1, 32'h21, 4'hF, 4'hF, 1'b0, 1'b1);
      applyStimulus(1'b1, 1'b1, 32'h22, 4'hF, 4'hF, 1'b0, 1'b1);
      checkOutput("prerst_inpkt", K_INPKT, 32'd1);
      checkOutput("prerst_beat", K_BEAT, 32'd4);
      applyStimulus(1'b1, 1'b0, 32'h23, 4'hF, 4'hF, 1'b0, 1'b1);
      #1;
      tvalid = 1'b0;
      resetn = 1'b0;
      checkOutput("rst_beat", K_BEAT, 32'd0);
      checkOutput("rst_stall", K_STALL, 32'd0);
      checkOutput("rst_inpkt", K_INPKT, 32'd0);
      checkOutput("rst_pbeats", K_PBEATS, 32'd0);
      @(negedge clk);
      #1;
      resetn = 1'b1;
      applyStimulus(1'b1, 1'b1, 32'h31, 4'hF, 4'hF, 1'b0, 1'b0);
      checkOutput("postrst_flags1", K_FLAGS, 32'd0);
      checkOutput("postrst_pbeats", K_PBEATS, 32'd1);
      applyStimulus(1'b1, 1'b1, 32'h32, 4'hF, 4'hF, 1'b1, 1'b0);
      checkOutput("postrst_flags2", K_FLAGS, 32'd0);
      checkOutput("postrst_pkt", K_PKT, 32'd1);
      checkOutput("postrst_beat", K_BEAT, 32'd2);
      applyStimulus(1'b0, 1'b0, 32'd0, 4'hF, 4'hF, 1'b0, 1'b0);

      for (int i = 0; i < 5 && sb.size() > 0; i++) @(negedge clk);
      #1;
      if (sb.size() > 0) begin
         tests_failed++;
         $display("[TB] FAIL scoreboard_drain: %0d pending, expected 0", sb.size());
      end
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
